// File: rtl/alsu_txn_driver.sv
// ---------------------------------------------------------------------------
// alsu_txn_driver
//
// Transaction-level initiator for the ALSU. It accepts operation requests on a
// valid/ready port and registers each one onto the ALSU input pins for one
// cycle. It captures the ALSU result a fixed latency later and queues it, with
// the invalid-stimulus flag, in a response FIFO that the consumer can stall.
// Sustains one operation per clock when the consumer keeps up.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_*                  operation fields (A, B, cin, serial_in, red_op_A/B,
//                          opcode, bypass_A/B, direction)
//   alsu_rst               ALSU reset, follows rst combinationally
//   alsu_*                 registered drive of the request fields (idle = 0)
//   alsu_out, alsu_leds    ALSU result inputs
//   rsp_valid/rsp_ready    response handshake at the FIFO head
//   rsp_out/leds/invalid   head entry (zero while the FIFO is empty)
//   txn_count              accepted requests, saturating
//   invalid_count          accepted invalid requests, saturating
// ---------------------------------------------------------------------------
module alsu_txn_driver #(
    parameter int ALSU_LAT   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_A,
    input  logic [2:0]       req_B,
    input  logic             req_cin,
    input  logic             req_serial_in,
    input  logic             req_red_op_A,
    input  logic             req_red_op_B,
    input  logic [2:0]       req_opcode,
    input  logic             req_bypass_A,
    input  logic             req_bypass_B,
    input  logic             req_direction,
    output logic             alsu_rst,
    output logic [2:0]       alsu_A,
    output logic [2:0]       alsu_B,
    output logic             alsu_cin,
    output logic             alsu_serial_in,
    output logic             alsu_red_op_A,
    output logic             alsu_red_op_B,
    output logic [2:0]       alsu_opcode,
    output logic             alsu_bypass_A,
    output logic             alsu_bypass_B,
    output logic             alsu_direction,
    input  logic [5:0]       alsu_out,
    input  logic [15:0]      alsu_leds,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [5:0]       rsp_out,
    output logic [15:0]      rsp_leds,
    output logic             rsp_invalid,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] invalid_count
);

    localparam int STAGES  = ALSU_LAT + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = PTR_W + 1;
    localparam int OCC_W   = $clog2(FIFO_DEPTH + STAGES + 1) + 1;
    localparam int VEC_W   = 16;
    localparam int ENTRY_W = 6 + 16 + 1;

    // Request fields packed in the same order as the alsu_* unpack below
    logic [VEC_W-1:0]   reqVec;
    logic [VEC_W-1:0]   alsuVec_q, alsuVec_d;

    logic [STAGES-1:0]  tagValid_q, tagValid_d;
    logic [STAGES-1:0]  tagInv_q, tagInv_d;

    logic [ENTRY_W-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [FCNT_W-1:0]  fifoCount_q, fifoCount_d;

    logic [CNT_W-1:0]   txnCount_q, txnCount_d;
    logic [CNT_W-1:0]   invCount_q, invCount_d;

    logic               accept;
    logic               reqInv;
    logic               push;
    logic               pop;
    logic [OCC_W-1:0]   inflight;
    logic [OCC_W-1:0]   occupancy;
    logic [ENTRY_W-1:0] headEntry;

    assign reqVec = {req_A, req_B, req_cin, req_serial_in, req_red_op_A,
                     req_red_op_B, req_opcode, req_bypass_A, req_bypass_B,
                     req_direction};

    // Credit check: every in-flight tag already owns a FIFO slot, so the FIFO
    // can never be pushed while full unless the same edge also pops.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGES; i++) begin
            inflight = inflight + OCC_W'(tagValid_q[i]);
        end
        occupancy = inflight + OCC_W'(fifoCount_q);
        req_ready = occupancy < OCC_W'(FIFO_DEPTH);
    end

    assign accept = req_valid && req_ready;
    assign reqInv = ((req_red_op_A | req_red_op_B) & (req_opcode[1] | req_opcode[2]))
                  | (req_opcode[1] & req_opcode[2]);
    assign push   = tagValid_q[STAGES-1];
    assign pop    = rsp_valid && rsp_ready;

    // Next-state for the drive register, tag pipeline, FIFO control and
    // counters. Cycles without an accept drive the all-zero idle vector.
    always_comb begin
        alsuVec_d   = accept ? reqVec : '0;
        tagValid_d  = {tagValid_q[STAGES-2:0], accept};
        tagInv_d    = {tagInv_q[STAGES-2:0], reqInv & accept};
        wrPtr_d     = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d     = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        fifoCount_d = fifoCount_q;
        if (push && !pop) begin
            fifoCount_d = fifoCount_q + FCNT_W'(1);
        end else if (!push && pop) begin
            fifoCount_d = fifoCount_q - FCNT_W'(1);
        end
        txnCount_d = txnCount_q;
        if (accept && (txnCount_q != '1)) begin
            txnCount_d = txnCount_q + CNT_W'(1);
        end
        invCount_d = invCount_q;
        if (accept && reqInv && (invCount_q != '1)) begin
            invCount_d = invCount_q + CNT_W'(1);
        end
    end

    // Control state; reset discards in-flight tags and queued responses
    always_ff @(posedge clk) begin
        if (rst) begin
            alsuVec_q   <= '0;
            tagValid_q  <= '0;
            tagInv_q    <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            txnCount_q  <= '0;
            invCount_q  <= '0;
        end else begin
            alsuVec_q   <= alsuVec_d;
            tagValid_q  <= tagValid_d;
            tagInv_q    <= tagInv_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fifoCount_q <= fifoCount_d;
            txnCount_q  <= txnCount_d;
            invCount_q  <= invCount_d;
        end
    end

    // FIFO storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifoMem_q[wrPtr_q] <= {alsu_out, alsu_leds, tagInv_q[STAGES-1]};
        end
    end

    assign headEntry   = fifoMem_q[rdPtr_q];
    assign rsp_valid   = (fifoCount_q != '0);
    assign rsp_out     = rsp_valid ? headEntry[ENTRY_W-1 -: 6] : '0;
    assign rsp_leds    = rsp_valid ? headEntry[16:1] : '0;
    assign rsp_invalid = rsp_valid ? headEntry[0] : 1'b0;

    assign alsu_rst = rst;
    assign {alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_red_op_A,
            alsu_red_op_B, alsu_opcode, alsu_bypass_A, alsu_bypass_B,
            alsu_direction} = alsuVec_q;

    assign txn_count     = txnCount_q;
    assign invalid_count = invCount_q;

endmodule

// File: tb/tb_alsu_txn_driver.sv
// ---------------------------------------------------------------------------
// tb_alsu_txn_driver
//
// Directed bench for alsu_txn_driver. A small two-register ALSU model closes
// the loop on the alsu_* pins. Each issued request pushes its hand-computed
// response onto a queue; a monitor pops and compares whenever a response is
// handed over. Direct checks cover latency, backpressure, counters and reset.
// ---------------------------------------------------------------------------
module tb_alsu_txn_driver;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] opcode;
        logic       cin;
        logic       serialIn;
        logic       redA;
        logic       redB;
        logic       bypA;
        logic       bypB;
        logic       dir;
    } req_t;

    typedef struct {
        logic [5:0]  out;
        logic [15:0] leds;
        logic        inv;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_A, req_B, req_opcode;
    logic        req_cin, req_serial_in, req_red_op_A, req_red_op_B;
    logic        req_bypass_A, req_bypass_B, req_direction;
    logic        alsu_rst;
    logic [2:0]  alsu_A, alsu_B, alsu_opcode;
    logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
    logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic        rsp_valid;
    logic        rspReady;
    logic [5:0]  rsp_out;
    logic [15:0] rsp_leds;
    logic        rsp_invalid;
    logic [15:0] txn_count;
    logic [15:0] invalid_count;

    int   errors = 0;
    int   checks = 0;
    int   cycleCnt = 0;
    int   lastPop = 0;
    int   prevPop = 0;
    rsp_t expQ[$];

    alsu_txn_driver #(.ALSU_LAT(2), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_cin(req_cin),
        .req_serial_in(req_serial_in), .req_red_op_A(req_red_op_A),
        .req_red_op_B(req_red_op_B), .req_opcode(req_opcode),
        .req_bypass_A(req_bypass_A), .req_bypass_B(req_bypass_B),
        .req_direction(req_direction),
        .alsu_rst(alsu_rst), .alsu_A(alsu_A), .alsu_B(alsu_B),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_opcode(alsu_opcode), .alsu_bypass_A(alsu_bypass_A),
        .alsu_bypass_B(alsu_bypass_B), .alsu_direction(alsu_direction),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .rsp_valid(rsp_valid), .rsp_ready(rspReady),
        .rsp_out(rsp_out), .rsp_leds(rsp_leds), .rsp_invalid(rsp_invalid),
        .txn_count(txn_count), .invalid_count(invalid_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // ALSU model: input register stage then output register stage
    logic [2:0] mA, mB, mOp;
    logic       mCin, mSer, mRedA, mRedB, mBypA, mBypB, mDir;

    always @(posedge clk) begin
        if (alsu_rst) begin
            {mA, mB, mOp, mCin, mSer, mRedA, mRedB, mBypA, mBypB, mDir} <= '0;
            alsu_out  <= '0;
            alsu_leds <= '0;
        end else begin
            mA <= alsu_A; mB <= alsu_B; mOp <= alsu_opcode; mCin <= alsu_cin;
            mSer <= alsu_serial_in; mRedA <= alsu_red_op_A; mRedB <= alsu_red_op_B;
            mBypA <= alsu_bypass_A; mBypB <= alsu_bypass_B; mDir <= alsu_direction;
            alsu_leds <= '0;
            if ((((mRedA | mRedB) & (mOp[1] | mOp[2])) | (mOp[1] & mOp[2])) == 1'b1) begin
                alsu_out  <= '0;
                alsu_leds <= 16'hFFFF;
            end else if (mBypA) begin
                alsu_out <= {3'b000, mA};
            end else if (mBypB) begin
                alsu_out <= {3'b000, mB};
            end else begin
                case (mOp)
                    3'b000:  alsu_out <= mRedA ? {5'b0, |mA} : mRedB ? {5'b0, |mB} : {3'b0, mA | mB};
                    3'b001:  alsu_out <= mRedA ? {5'b0, ^mA} : mRedB ? {5'b0, ^mB} : {3'b0, mA ^ mB};
                    3'b010:  alsu_out <= 6'(mA) + 6'(mB) + 6'(mCin);
                    3'b011:  alsu_out <= 6'(mA) * 6'(mB);
                    3'b100:  alsu_out <= mDir ? {alsu_out[4:0], mSer} : {mSer, alsu_out[5:1]};
                    default: alsu_out <= mDir ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
                     name, actual, expected, cycleCnt);
        end
    endtask

    // Monitor: a handover happens on the next edge when valid and ready hold
    always @(negedge clk) begin
        if (!rst && rsp_valid && rspReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedRsp: got out=%0d inv=%0b expected no response",
                         rsp_out, rsp_invalid);
            end else begin
                rsp_t e;
                e = expQ.pop_front();
                checkOutput("rspOut", 32'(rsp_out), 32'(e.out));
                checkOutput("rspLeds", 32'(rsp_leds), 32'(e.leds));
                checkOutput("rspInvalid", 32'(rsp_invalid), 32'(e.inv));
                prevPop = lastPop;
                lastPop = cycleCnt;
            end
        end
    end

    function automatic req_t mkReq(input logic [2:0] a, input logic [2:0] b,
                                   input logic [2:0] op);
        req_t r;
        r = '{a: a, b: b, opcode: op, cin: 1'b0, serialIn: 1'b0, redA: 1'b0,
              redB: 1'b0, bypA: 1'b0, bypB: 1'b0, dir: 1'b0};
        return r;
    endfunction

    task automatic driveReq(input req_t r);
        req_A = r.a; req_B = r.b; req_opcode = r.opcode; req_cin = r.cin;
        req_serial_in = r.serialIn; req_red_op_A = r.redA; req_red_op_B = r.redB;
        req_bypass_A = r.bypA; req_bypass_B = r.bypB; req_direction = r.dir;
    endtask

    // Issue one request; returns right after the accepting edge
    task automatic applyStimulus(input req_t r, input rsp_t e, input bit expectRsp);
        int guard;
        @(negedge clk);
        driveReq(r);
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput("reqReadyTimeout", 32'(req_ready), 32'd1);
        end
        @(posedge clk);
        if (expectRsp) expQ.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        driveReq(mkReq(3'd0, 3'd0, 3'd0));
    endtask

    task automatic setRspReady(input logic v);
        @(posedge clk);
        #1 rspReady = v;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (expQ.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        req_t r;
        bit   held;
        rst = 1'b1;
        rspReady = 1'b1;
        req_valid = 1'b0;
        driveReq(mkReq(3'd0, 3'd0, 3'd0));
        repeat (3) @(negedge clk);
        checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("resetTxnCount", 32'(txn_count), 32'd0);
        checkOutput("resetAlsuRst", 32'(alsu_rst), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetReqReady", 32'(req_ready), 32'd1);
        checkOutput("resetAlsuOpcode", 32'(alsu_opcode), 32'd0);

        // ADD 3+2+1 with latency check: accept at edge k, rsp_valid after k+3
        $display("[TB] test 1: ADD latency");
        r = mkReq(3'd3, 3'd2, 3'b010);
        r.cin = 1'b1;
        applyStimulus(r, '{out: 6'd6, leds: 16'h0, inv: 1'b0}, 1'b1);
        idle();
        checkOutput("t1TxnCount", 32'(txn_count), 32'd1);
        checkOutput("t1AlsuA", 32'(alsu_A), 32'd3);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t1NotYetValid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("t1ValidAtK3", 32'(rsp_valid), 32'd1);
        waitDrain();

        // MULT 3*3 then OR 5|2 back-to-back
        $display("[TB] test 2: back-to-back");
        applyStimulus(mkReq(3'd3, 3'd3, 3'b011), '{out: 6'd9, leds: 16'h0, inv: 1'b0}, 1'b1);
        applyStimulus(mkReq(3'd5, 3'd2, 3'b000), '{out: 6'd7, leds: 16'h0, inv: 1'b0}, 1'b1);
        idle();
        waitDrain();
        checkOutput("t2ConsecutivePops", 32'(lastPop - prevPop), 32'd1);

        // Backpressure: four ADDs fill the credits, fifth must wait
        $display("[TB] test 3: backpressure");
        setRspReady(1'b0);
        applyStimulus(mkReq(3'd1, 3'd1, 3'b010), '{out: 6'd2, leds: 16'h0, inv: 1'b0}, 1'b1);
        applyStimulus(mkReq(3'd2, 3'd3, 3'b010), '{out: 6'd5, leds: 16'h0, inv: 1'b0}, 1'b1);
        r = mkReq(3'd7, 3'd7, 3'b010);
        r.cin = 1'b1;
        applyStimulus(r, '{out: 6'd15, leds: 16'h0, inv: 1'b0}, 1'b1);
        applyStimulus(mkReq(3'd4, 3'd0, 3'b010), '{out: 6'd4, leds: 16'h0, inv: 1'b0}, 1'b1);
        @(negedge clk);
        driveReq(mkReq(3'd2, 3'd3, 3'b011));
        req_valid = 1'b1;
        expQ.push_back('{out: 6'd6, leds: 16'h0, inv: 1'b0});
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (req_ready) held = 1'b0;
            @(negedge clk);
        end
        checkOutput("t3ReadyHeldLow", 32'(held), 32'd1);
        checkOutput("t3FifoFullValid", 32'(rsp_valid), 32'd1);
        setRspReady(1'b1);
        @(posedge clk);
        #1 checkOutput("t3ReadyOnFirstPop", 32'(req_ready), 32'd1);
        @(posedge clk);
        idle();
        waitDrain();

        // Invalid opcode, then reduction on OR which is valid
        $display("[TB] test 4: invalid flag");
        applyStimulus(mkReq(3'd1, 3'd2, 3'b110), '{out: 6'd0, leds: 16'hFFFF, inv: 1'b1}, 1'b1);
        r = mkReq(3'd4, 3'd0, 3'b000);
        r.redA = 1'b1;
        applyStimulus(r, '{out: 6'd1, leds: 16'h0, inv: 1'b0}, 1'b1);
        idle();
        checkOutput("t4InvalidCount", 32'(invalid_count), 32'd1);
        waitDrain();

        // Bypass A
        $display("[TB] test 5: bypass");
        r = mkReq(3'd2, 3'd5, 3'b011);
        r.bypA = 1'b1;
        applyStimulus(r, '{out: 6'd2, leds: 16'h0, inv: 1'b0}, 1'b1);
        idle();
        checkOutput("t5AlsuBypassA", 32'(alsu_bypass_A), 32'd1);
        checkOutput("t5AlsuOpcode", 32'(alsu_opcode), 32'd3);
        @(negedge clk);
        checkOutput("t5IdleOpcode", 32'(alsu_opcode), 32'd0);
        checkOutput("t5IdleBypassA", 32'(alsu_bypass_A), 32'd0);
        checkOutput("t5TxnCount", 32'(txn_count), 32'd11);
        waitDrain();

        // Reset mid-flight: two accepts then reset on the following edge
        $display("[TB] test 6: reset mid-flight");
        applyStimulus(mkReq(3'd1, 3'd1, 3'b010), '{out: 6'd0, leds: 16'h0, inv: 1'b0}, 1'b0);
        applyStimulus(mkReq(3'd1, 3'd2, 3'b110), '{out: 6'd0, leds: 16'h0, inv: 1'b0}, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6RstValid", 32'(rsp_valid), 32'd0);
        checkOutput("t6RstAlsuA", 32'(alsu_A), 32'd0);
        checkOutput("t6RstAlsuOpcode", 32'(alsu_opcode), 32'd0);
        checkOutput("t6RstTxnCount", 32'(txn_count), 32'd0);
        checkOutput("t6RstInvCount", 32'(invalid_count), 32'd0);
        checkOutput("t6AlsuRst", 32'(alsu_rst), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6ReadyAfterRst", 32'(req_ready), 32'd1);
        checkOutput("t6AlsuRstLow", 32'(alsu_rst), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("t6NoRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("t6TxnCountStill0", 32'(txn_count), 32'd0);
        checkOutput("t6QueueEmpty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
